alu_issue: RTL and testbench

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 112 +++++++++++
 tb/tb_alu_issue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Two-state issue stage for an external 16-bit ALU: latches operands from an
// eight-entry register file, then writes the ALU result back on the next edge.
module alu_issue #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [15:0] alu_inA,
  output logic [15:0] alu_inB,
  output logic [3:0]  alu_opcode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_carry_out,
  output logic        retire,
  output logic [15:0] retire_count,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        carry_flag
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t      state, state_nxt;
  logic [15:0] regs [NREGS];
  logic [3:0]  op_q;
  logic [2:0]  rd_q;
  logic [15:0] a_q, b_q;
  logic        accept;

  logic [3:0]  f_op;
  logic [2:0]  f_rd, f_rs;
  logic        f_imm_sel;
  logic [4:0]  f_imm5;

  assign {f_op, f_rd, f_rs, f_imm_sel, f_imm5} = instr;

  // R0 is hard-wired to zero on every read path.
  function automatic logic [15:0] read_reg(input logic [2:0] idx);
    return (idx == 3'd0) ? 16'h0000 : regs[idx];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation ordering cannot change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    retire      = 1'b0;
    accept      = 1'b0;
    alu_inA     = 16'h0000;
    alu_inB     = 16'h0000;
    alu_opcode  = 4'h0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        retire     = 1'b1;
        alu_inA    = a_q;
        alu_inB    = b_q;
        alu_opcode = op_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign alu_carry_in = carry_flag;
  assign dbg_data     = read_reg(dbg_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 4'h0;
      rd_q <= 3'd0;
      a_q  <= 16'h0000;
      b_q  <= 16'h0000;
    end else if (accept) begin
      op_q <= f_op;
      rd_q <= f_rd;
      a_q  <= read_reg(f_rd);
      b_q  <= f_imm_sel ? {11'b0, f_imm5} : read_reg(f_rs);
    end
  end

  // NOTE: the register file is architecturally defined to be zero after
  // reset, so unlike a plain data RAM it must be reset entry by entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
      carry_flag   <= 1'b0;
      retire_count <= 16'h0000;
    end else if (state == EXEC) begin
      if (rd_q != 3'd0) regs[rd_q] <= alu_result;
      carry_flag   <= alu_carry_out;
      retire_count <= retire_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a behavioural ALU, a directed vector table run back to
// back, and hand-written sequences for held-valid and reset-during-EXEC.
module tb_alu_issue;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_inA, alu_inB;
  logic [3:0]  alu_opcode;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        alu_carry_out;
  logic        retire;
  logic [15:0] retire_count;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        carry_flag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_inA      (alu_inA),
    .alu_inB      (alu_inB),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_result   (alu_result),
    .alu_carry_out(alu_carry_out),
    .retire       (retire),
    .retire_count (retire_count),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data),
    .carry_flag   (carry_flag)
  );

  // External ALU: ADD uses carry-in, SUB reports borrow as carry-out.
  always_comb begin
    alu_result    = 16'h0000;
    alu_carry_out = 1'b0;
    case (alu_opcode)
      OP_ADD: {alu_carry_out, alu_result} = {1'b0, alu_inA} + {1'b0, alu_inB} + {16'b0, alu_carry_in};
      OP_SUB: {alu_carry_out, alu_result} = {1'b0, alu_inA} - {1'b0, alu_inB};
      OP_AND: alu_result = alu_inA & alu_inB;
      OP_OR:  alu_result = alu_inA | alu_inB;
      OP_XOR: alu_result = alu_inA ^ alu_inB;
      OP_MOV: alu_result = alu_inB;
      default: ;
    endcase
  end

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic        isel;
    logic [4:0]  imm;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic        exp_cin;
    logic [15:0] exp_rd;
    logic        exp_carry;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs, input logic isel,
                                     input logic [4:0] imm);
    return {op, rd, rs, isel, imm};
  endfunction

  function automatic vec_t mkv(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                               input logic isel, input logic [4:0] imm, input logic [15:0] a,
                               input logic [15:0] b, input logic cin, input logic [15:0] r,
                               input logic c);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.isel = isel; v.imm = imm;
    v.exp_a = a; v.exp_b = b; v.exp_cin = cin; v.exp_rd = r; v.exp_carry = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_reg_chk(input string name, input logic [2:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    check(name, dbg_data, exp);
  endtask

  int rets;

  initial begin
    //            op      rd  rs  is imm    A        B        cin  Rd       carry
    vecs[0]  = mkv(OP_ADD, 1, 0, 1, 5'd5,  16'h0000, 16'h0005, 0, 16'h0005, 0);
    vecs[1]  = mkv(OP_MOV, 2, 0, 1, 5'd1,  16'h0000, 16'h0001, 0, 16'h0001, 0);
    vecs[2]  = mkv(OP_SUB, 1, 2, 0, 5'd0,  16'h0005, 16'h0001, 0, 16'h0004, 0);
    vecs[3]  = mkv(OP_MOV, 1, 0, 1, 5'd0,  16'h0004, 16'h0000, 0, 16'h0000, 0);
    vecs[4]  = mkv(OP_SUB, 1, 2, 0, 5'd0,  16'h0000, 16'h0001, 0, 16'hFFFF, 1);
    vecs[5]  = mkv(OP_AND, 5, 0, 1, 5'd0,  16'h0000, 16'h0000, 1, 16'h0000, 0);
    vecs[6]  = mkv(OP_MOV, 3, 0, 1, 5'd7,  16'h0000, 16'h0007, 0, 16'h0007, 0);
    vecs[7]  = mkv(OP_ADD, 1, 2, 0, 5'd0,  16'hFFFF, 16'h0001, 0, 16'h0000, 1);
    vecs[8]  = mkv(OP_ADD, 3, 0, 1, 5'd0,  16'h0007, 16'h0000, 1, 16'h0008, 0);
    vecs[9]  = mkv(OP_OR,  4, 0, 1, 5'h12, 16'h0000, 16'h0012, 0, 16'h0012, 0);
    vecs[10] = mkv(OP_XOR, 4, 3, 0, 5'd0,  16'h0012, 16'h0008, 0, 16'h001A, 0);
    vecs[11] = mkv(OP_ADD, 0, 0, 1, 5'd9,  16'h0000, 16'h0009, 0, 16'h0000, 0);
    vecs[12] = mkv(OP_ADD, 6, 4, 0, 5'd0,  16'h0000, 16'h001A, 0, 16'h001A, 0);
    vecs[13] = mkv(OP_ADD, 6, 0, 1, 5'd31, 16'h001A, 16'h001F, 0, 16'h0039, 0);

    // Reset with a valid instruction pending: nothing may be accepted.
    rst_n       = 1'b0;
    instr_valid = 1'b1;
    instr       = mk(OP_MOV, 1, 0, 1, 5'd3);
    dbg_addr    = 3'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_ready", {15'b0, instr_ready}, 16'h0001);
    check("rst_retire", {15'b0, retire}, 16'h0000);
    check("rst_count", retire_count, 16'h0000);
    check("rst_carry", {15'b0, carry_flag}, 16'h0000);
    check("rst_alu_inA", alu_inA, 16'h0000);
    read_reg_chk("rst_r1", 3'd1, 16'h0000);
    instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      instr       = mk(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].isel, vecs[i].imm);
      instr_valid = 1'b1;
      #1;
      check($sformatf("v%0d_ready_idle", i), {15'b0, instr_ready}, 16'h0001);
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 16'hFFFF;
      check($sformatf("v%0d_alu_inA", i), alu_inA, vecs[i].exp_a);
      check($sformatf("v%0d_alu_inB", i), alu_inB, vecs[i].exp_b);
      check($sformatf("v%0d_alu_op", i), {12'b0, alu_opcode}, {12'b0, vecs[i].op});
      check($sformatf("v%0d_cin", i), {15'b0, alu_carry_in}, {15'b0, vecs[i].exp_cin});
      check($sformatf("v%0d_retire_exec", i), {15'b0, retire}, 16'h0001);
      check($sformatf("v%0d_ready_exec", i), {15'b0, instr_ready}, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      read_reg_chk($sformatf("v%0d_rd", i), vecs[i].rd, vecs[i].exp_rd);
      check($sformatf("v%0d_carry", i), {15'b0, carry_flag}, {15'b0, vecs[i].exp_carry});
      check($sformatf("v%0d_count", i), retire_count, 16'(i + 1));
      check($sformatf("v%0d_retire_idle", i), {15'b0, retire}, 16'h0000);
    end
    check("idle_alu_inA", alu_inA, 16'h0000);
    check("idle_alu_inB", alu_inB, 16'h0000);
    check("idle_alu_op", {12'b0, alu_opcode}, 16'h0000);

    // Held valid for six cycles with changing words: accepts on cycles 0,2,4.
    rets = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      instr       = mk(OP_MOV, 7, 0, 1, 5'(c + 1));
      instr_valid = 1'b1;
      #1;
      check($sformatf("held_ready_c%0d", c), {15'b0, instr_ready}, (c % 2 == 0) ? 16'h0001 : 16'h0000);
      if (retire) rets++;
    end
    @(negedge clk);
    instr_valid = 1'b0;
    check("held_retires", 16'(rets), 16'd3);
    check("held_count", retire_count, 16'd17);
    read_reg_chk("held_r7", 3'd7, 16'h0005);

    // Reset asserted shortly after the accept edge of a write to R4.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    instr       = mk(OP_MOV, 4, 0, 1, 5'd9);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    rets        = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (retire) rets++;
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (retire) rets++;
    check("abort_retires", 16'(rets), 16'd0);
    check("abort_count", retire_count, 16'h0000);
    check("abort_carry", {15'b0, carry_flag}, 16'h0000);
    check("abort_ready", {15'b0, instr_ready}, 16'h0001);
    read_reg_chk("abort_r4", 3'd4, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
